// File: rtl/fpu_arb_pkg.sv
// rtl/fpu_arb_pkg.sv - shared types and constants for the FPU arbiter
package fpu_arb_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [DATA_W-1:0] TIMEOUT_NAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/fpu_arbiter_rr_pick.sv
// rtl/fpu_arbiter_rr_pick.sv - combinational round-robin picker
module rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from last+1 upward with wraparound; the first active request wins.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IDX_W'((int'(last) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - round-robin sharing of one FPU unit; FPU_ARB_TIMEOUT_EN adds a wait watchdog
module fpu_arbiter
  import fpu_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [DATA_W*NREQ-1:0] req_op,
  output logic [NREQ-1:0]        req_ready,
  output logic [NREQ-1:0]        resp_valid,
  output logic [DATA_W-1:0]      resp_result,
  output logic                   resp_err,
  output logic                   busy,
  output logic [DATA_W-1:0]      unit_op,
  output logic                   unit_start,
  input  logic                   unit_valid,
  input  logic [DATA_W-1:0]      unit_result
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fpu_arbiter: NREQ must be 2..8 and TIMEOUT at least 1");
  end

  state_e           state;
  logic [IDX_W-1:0] grant;
  logic [IDX_W-1:0] last;
  logic [NREQ-1:0]  pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [DATA_W-1:0] op_sel;

  rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (req_valid),
    .last    (last),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx),
    .any     (pick_any)
  );

  assign op_sel     = req_op[int'(pick_idx)*DATA_W +: DATA_W];
  assign req_ready  = (state == IDLE) ? pick_gnt : '0;
  assign unit_start = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign resp_valid = (state == RESP) ? (NREQ'(1) << grant) : '0;

`ifdef FPU_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] wait_cnt;
  logic             timeout_hit;

  assign timeout_hit = (state == WAIT) && !unit_valid &&
                       (wait_cnt == CNT_W'(TIMEOUT - 1));

  // Watchdog: count idle WAIT cycles and flag the response when it expires.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
      resp_err <= 1'b0;
    end else if (state == ISSUE) begin
      wait_cnt <= '0;
    end else if (state == WAIT) begin
      if (unit_valid) begin
        resp_err <= 1'b0;
      end else begin
        wait_cnt <= wait_cnt + CNT_W'(1);
        if (timeout_hit) resp_err <= 1'b1;
      end
    end
  end
`else
  assign resp_err = 1'b0;
`endif

  // Main sequencer: accept, issue, wait for the unit, respond.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      grant       <= '0;
      last        <= IDX_W'(NREQ - 1);
      unit_op     <= '0;
      resp_result <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            unit_op <= op_sel;
            grant   <= pick_idx;
            last    <= pick_idx;
            state   <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (unit_valid) begin
            resp_result <= unit_result;
            state       <= RESP;
          end
`ifdef FPU_ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            resp_result <= TIMEOUT_NAN;
            state       <= RESP;
          end
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - self-checking bench for fpu_arbiter
module tb_fpu_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NREQ-1:0]   req_valid;
  logic [32*NREQ-1:0] req_op;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   resp_valid;
  logic [31:0]       resp_result;
  logic              resp_err;
  logic              busy;
  logic [31:0]       unit_op;
  logic              unit_start;
  logic              unit_valid;
  logic [31:0]       unit_result;

  fpu_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_op      (req_op),
    .req_ready   (req_ready),
    .resp_valid  (resp_valid),
    .resp_result (resp_result),
    .resp_err    (resp_err),
    .busy        (busy),
    .unit_op     (unit_op),
    .unit_start  (unit_start),
    .unit_valid  (unit_valid),
    .unit_result (unit_result)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Unit emulation: mode 0 answers udelay cycles after start with op minus one exponent step
  int umode  = 0;
  int udelay = 1;
  bit upulse = 0;
  int cd     = 0;
  bit start_seen = 0;
  bit acc_seen   = 0;

  always @(negedge clk) begin
    start_seen = unit_start;
    acc_seen   = |req_ready;
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (umode == 1) begin
      unit_valid  = ($urandom_range(0, 2) == 0);
      unit_result = $urandom;
    end else begin
      unit_valid = 1'b0;
      if (start_seen && udelay > 0) cd = udelay;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          unit_valid  = 1'b1;
          unit_result = unit_op - 32'h0080_0000;
        end
      end
      if (upulse && acc_seen) begin
        unit_valid  = 1'b1;
        unit_result = 32'hDEAD_BEEF;
      end
    end
  endtask

  // Transaction-level reference: one pending op with its accept and result cycle numbers
  int          cyc     = 0;
  bit          pend    = 0;
  int          acc_cyc = 0;
  int          val_cyc = -1;
  int          win     = 0;
  int          m_last  = NREQ - 1;
  logic [31:0] m_res   = '0;
  logic [31:0] m_op    = '0;
  bit          m_err   = 0;

  always @(negedge clk) begin : model
    int         g;
    logic [3:0] e_ready;
    logic [3:0] e_resp;
    bit         e_start;
    bit         in_wait;
    if (reset) begin
      pend   = 0;
      m_last = NREQ - 1;
      m_res  = '0;
      m_op   = '0;
      m_err  = 0;
    end else begin
      g       = -1;
      e_ready = '0;
      if (!pend)
        for (int k = 1; k <= NREQ; k++)
          if (g < 0 && req_valid[(m_last + k) % NREQ]) g = (m_last + k) % NREQ;
      if (g >= 0) e_ready[g] = 1'b1;
      e_start = pend && (cyc == acc_cyc + 1);
      in_wait = pend && (cyc >= acc_cyc + 2) && (val_cyc < 0);
      e_resp  = (pend && val_cyc >= 0 && cyc == val_cyc + 1) ? 4'(1 << win) : 4'b0;
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_unit_start", 32'(unit_start), 32'(e_start));
      chk("m_resp_valid", 32'(resp_valid), 32'(e_resp));
      chk("m_resp_result", resp_result, m_res);
      chk("m_resp_err", 32'(resp_err), 32'(m_err));
      chk("m_busy", 32'(busy), 32'(pend));
      chk("m_unit_op", unit_op, m_op);
      if (g >= 0) begin
        pend    = 1;
        acc_cyc = cyc;
        val_cyc = -1;
        win     = g;
        m_last  = g;
        m_op    = req_op[32*g +: 32];
      end else if (in_wait && unit_valid) begin
        val_cyc = cyc;
        m_res   = unit_result;
        m_err   = 0;
      end
`ifdef FPU_ARB_TIMEOUT_EN
      else if (in_wait && (cyc - acc_cyc - 1 == TIMEOUT)) begin
        val_cyc = cyc;
        m_res   = 32'h7FC0_0000;
        m_err   = 1;
      end
`endif
      else if (e_resp != 0) begin
        pend = 0;
      end
    end
    cyc++;
  end

  // One request through to its response; lat counts cycles from the accept cycle
  task automatic run_op(input logic [3:0] mask, output int lat, output logic [3:0] rv,
                        output logic [31:0] res, output bit err);
    lat = -1;
    rv  = '0;
    res = '0;
    err = 0;
    cycle();
    req_valid = mask;
    @(negedge clk);
    cycle();
    req_valid = '0;
    for (int t = 1; t < 60; t++) begin
      @(negedge clk);
      if (|resp_valid) begin
        lat = t;
        rv  = resp_valid;
        res = resp_result;
        err = resp_err;
        break;
      end
      cycle();
    end
  endtask

  int          lat;
  logic [3:0]  rv;
  logic [31:0] res;
  bit          err;
  int          nresp;
  int          prev;
  int          busy_cnt;

  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_op      = '0;
    unit_valid  = 1'b0;
    unit_result = '0;
    repeat (2) cycle();
    reset = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_resp_valid", 32'(resp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_unit_op", unit_op, 32'h0);
    chk("rst_resp_result", resp_result, 32'h0);

    // Single request from requester 1
    cycle();
    req_valid = 4'b0010;
    req_op[63:32] = 32'h4080_0000;
    @(negedge clk);
    chk("single_ready_c0", 32'(req_ready), 32'h2);
    chk("single_busy_c0", 32'(busy), 32'h0);
    cycle();
    req_valid = '0;
    @(negedge clk);
    chk("single_start_c1", 32'(unit_start), 32'h1);
    chk("single_busy_c1", 32'(busy), 32'h1);
    chk("single_unit_op", unit_op, 32'h4080_0000);
    cycle();
    @(negedge clk);
    chk("single_start_c2", 32'(unit_start), 32'h0);
    chk("single_busy_c2", 32'(busy), 32'h1);
    chk("single_resp_c2", 32'(resp_valid), 32'h0);
    cycle();
    @(negedge clk);
    chk("single_resp_c3", 32'(resp_valid), 32'h2);
    chk("single_result_c3", resp_result, 32'h4000_0000);
    chk("single_busy_c3", 32'(busy), 32'h1);
    cycle();
    @(negedge clk);
    chk("single_busy_c4", 32'(busy), 32'h0);

    // Slow unit with a spurious valid during ISSUE
    udelay = 6;
    upulse = 1;
    cycle();
    req_op[95:64] = 32'h4100_0000;
    run_op(4'b0100, lat, rv, res, err);
    chk("slow_latency", lat, 32'd8);
    chk("slow_resp_valid", 32'(rv), 32'h4);
    chk("slow_result", res, 32'h4080_0000);
    udelay = 1;
    upulse = 0;

    // Fairness with all requesters continuously valid
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();
    for (int i = 0; i < NREQ; i++) req_op[32*i +: 32] = 32'h4000_0000 + 32'(i) * 32'h0100_0000;
    req_valid = 4'b1111;
    nresp = 0;
    prev  = -1;
    for (int t = 0; t < 200 && nresp < 16; t++) begin
      @(negedge clk);
      if (|resp_valid) begin
        chk("fair_grant", 32'(resp_valid), 32'(1 << (nresp % NREQ)));
        chk("fair_result", resp_result,
            32'h4000_0000 + 32'(nresp % NREQ) * 32'h0100_0000 - 32'h0080_0000);
        if (prev >= 0) chk("fair_gap", t - prev, 32'd4);
        prev = t;
        nresp++;
      end
      cycle();
    end
    req_valid = '0;
    chk("fair_count", nresp, 32'd16);

    // Reset while waiting on the unit, then a late valid
    udelay = 0;
    cycle();
    req_valid = 4'b0001;
    cycle();
    req_valid = '0;
    cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    unit_valid  = 1'b1;
    unit_result = 32'h1234_5678;
    @(negedge clk);
    chk("rstw_req_ready", 32'(req_ready), 32'h0);
    chk("rstw_resp_valid", 32'(resp_valid), 32'h0);
    chk("rstw_busy", 32'(busy), 32'h0);
    chk("rstw_unit_op", unit_op, 32'h0);
    chk("rstw_resp_result", resp_result, 32'h0);
    chk("rstw_resp_err", 32'(resp_err), 32'h0);
    chk("rstw_unit_start", 32'(unit_start), 32'h0);
    for (int t = 0; t < 4; t++) begin
      cycle();
      @(negedge clk);
      chk("rstw_no_resp", 32'(resp_valid), 32'h0);
    end
    udelay = 1;
    cycle();
    req_valid = 4'b1111;
    @(negedge clk);
    chk("rstw_next_grant", 32'(req_ready), 32'h1);
    cycle();
    req_valid = '0;
    repeat (4) cycle();

    // Unit that never answers
    udelay = 0;
`ifdef FPU_ARB_TIMEOUT_EN
    run_op(4'b1000, lat, rv, res, err);
    chk("to_latency", lat, 32'd18);
    chk("to_resp_valid", 32'(rv), 32'h8);
    chk("to_result", res, 32'h7FC0_0000);
    chk("to_err", 32'(err), 32'h1);
`else
    cycle();
    req_valid = 4'b1000;
    cycle();
    req_valid = '0;
    busy_cnt = 0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      if (busy && resp_valid == 0) busy_cnt++;
      cycle();
    end
    chk("noto_busy_held", busy_cnt, 32'd40);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
`endif
    udelay = 1;

    // Randomized traffic against the reference model
    umode = 1;
    for (int t = 0; t < 1500; t++) begin
      cycle();
      req_valid = 4'($urandom);
      for (int i = 0; i < NREQ; i++) req_op[32*i +: 32] = $urandom;
      reset = ($urandom_range(0, 199) == 0);
    end
    cycle();
    reset = 1'b0;
    req_valid = '0;
    repeat (3) cycle();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
